// File: rtl/upload_pkg.sv
// Shared types and widths for the upload arbiter slice.
// State encoding, datapath idle code and field widths.
package upload_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_e;

   localparam logic [1:0] UPLOAD_FSM_IDLE = 2'b00;

   localparam int FLIT_W_DEF  = 16;
   localparam int FLITS_MAX_W = 4;
   localparam int INV_IDS_W   = 4;

endpackage

// File: rtl/upload_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// A tie goes to the source that did not win last time.
module upload_rr_arb2
   import upload_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       gnt_en,
   output logic [1:0] gnt
);

   logic last_q;
   logic last_d;

   // one-hot grant from the current requests and the pointer
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // pointer moves only when a grant is actually taken
   always_comb begin
      last_d = last_q;
      if (gnt_en && (gnt != 2'b00)) begin
         last_d = gnt[1];
      end
   end

   // pointer starts at 1 so source 0 wins the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/upload_arbiter.sv
// Shares one upload datapath between two message sources.
// Grants round-robin, loads the datapath, then tracks it to completion.
module upload_arbiter
   import upload_pkg::*;
#(
   parameter int FLIT_W   = FLIT_W_DEF,
   parameter int START_TO = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   input  logic [FLIT_W-1:0]      req0_head_flit,
   input  logic [FLIT_W-1:0]      req0_addrhi,
   input  logic [FLIT_W-1:0]      req0_addrlo,
   input  logic [FLITS_MAX_W-1:0] req0_flits_max,
   input  logic                   req0_en_inv_ids,
   input  logic [INV_IDS_W-1:0]   req0_inv_ids,
   input  logic                   req1_valid,
   input  logic [FLIT_W-1:0]      req1_head_flit,
   input  logic [FLIT_W-1:0]      req1_addrhi,
   input  logic [FLIT_W-1:0]      req1_addrlo,
   input  logic [FLITS_MAX_W-1:0] req1_flits_max,
   input  logic                   req1_en_inv_ids,
   input  logic [INV_IDS_W-1:0]   req1_inv_ids,
   output logic                   req0_ack,
   output logic                   req1_ack,
   input  logic [1:0]             up_fsm_state,
   output logic                   up_v_flits_in,
   output logic [FLIT_W-1:0]      up_head_flit,
   output logic [FLIT_W-1:0]      up_addrhi,
   output logic [FLIT_W-1:0]      up_addrlo,
   output logic [FLITS_MAX_W-1:0] up_flits_max,
   output logic                   up_en_inv_ids,
   output logic [INV_IDS_W-1:0]   up_inv_ids,
   output logic                   grant_id,
   output logic                   busy,
   output logic                   start_err
);

   localparam logic [3:0] TO_LAST = 4'(START_TO - 1);

   arb_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic err_q, err_d;
   logic gid_q, gid_d;

   logic [FLIT_W-1:0]      head_q, head_d;
   logic [FLIT_W-1:0]      hi_q, hi_d;
   logic [FLIT_W-1:0]      lo_q, lo_d;
   logic [FLITS_MAX_W-1:0] fm_q, fm_d;
   logic                   en_q, en_d;
   logic [INV_IDS_W-1:0]   ids_q, ids_d;

   logic [1:0] gnt;
   logic       arb_en;

   assign arb_en = (state_q == IDLE);

   upload_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({req1_valid, req0_valid}),
      .gnt_en (arb_en),
      .gnt    (gnt)
   );

   // next state, watchdog and hold-register capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      gid_d   = gid_q;
      head_d  = head_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      fm_d    = fm_q;
      en_d    = en_q;
      ids_d   = ids_q;
      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               gid_d   = gnt[1];
               state_d = LOAD;
               if (gnt[1]) begin
                  head_d = req1_head_flit;
                  hi_d   = req1_addrhi;
                  lo_d   = req1_addrlo;
                  fm_d   = req1_flits_max;
                  en_d   = req1_en_inv_ids;
                  ids_d  = req1_inv_ids;
               end else begin
                  head_d = req0_head_flit;
                  hi_d   = req0_addrhi;
                  lo_d   = req0_addrlo;
                  fm_d   = req0_flits_max;
                  en_d   = req0_en_inv_ids;
                  ids_d  = req0_inv_ids;
               end
            end
         end
         LOAD: begin
            state_d = WAIT_BUSY;
            cnt_d   = '0;
         end
         WAIT_BUSY: begin
            if (up_fsm_state != UPLOAD_FSM_IDLE) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == TO_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WAIT_DONE: begin
            if (up_fsm_state == UPLOAD_FSM_IDLE) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, watchdog and hold registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         gid_q   <= 1'b0;
         head_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         fm_q    <= '0;
         en_q    <= 1'b0;
         ids_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         gid_q   <= gid_d;
         head_q  <= head_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         fm_q    <= fm_d;
         en_q    <= en_d;
         ids_q   <= ids_d;
      end
   end

   assign up_v_flits_in = (state_q == LOAD);
   assign req0_ack      = (state_q == LOAD) && !gid_q;
   assign req1_ack      = (state_q == LOAD) && gid_q;
   assign up_en_inv_ids = (state_q == LOAD) && en_q;
   assign up_head_flit  = head_q;
   assign up_addrhi     = hi_q;
   assign up_addrlo     = lo_q;
   assign up_flits_max  = fm_q;
   assign up_inv_ids    = ids_q;
   assign grant_id      = gid_q;
   assign busy          = (state_q != IDLE);
   assign start_err     = err_q;

endmodule

// File: doc/upload_arbiter.md
Name: upload_arbiter

Overview:
- Shares one upload_fsm_datapath instance between two message sources: req0 (cache-side requests) and req1 (memory-side responses/invalidations).
- Round-robin arbitration; latches the winner's header, address and invalidation fields into hold registers.
- Pulses the datapath's v_flits_in, then tracks its fsm_state until the upload finishes before granting again.
- A start watchdog recovers if the datapath never leaves idle.

Parameters:
FLIT_W, 16, flit/head/address field width
START_TO, 4, cycles allowed in WAIT_BUSY for the datapath to leave idle before abort (range 1-15)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
req0_valid  in  1  source 0 has a message pending; fields held stable until ack
req0_head_flit  in  FLIT_W  head flit
req0_addrhi  in  FLIT_W  address high
req0_addrlo  in  FLIT_W  address low
req0_flits_max  in  4  flit count of message
req0_en_inv_ids  in  1  message carries invalidation ids
req0_inv_ids  in  4  invalidation target ids
req1_*  in  (same set as req0)  source 1
req0_ack  out  1  one-cycle pulse: req0 message captured
req1_ack  out  1  one-cycle pulse: req1 message captured
up_fsm_state  in  2  datapath fsm_state; 2'b00 = idle
up_v_flits_in  out  1  one-cycle load strobe to datapath
up_head_flit, up_addrhi, up_addrlo  out  FLIT_W  held fields to datapath
up_flits_max  out  4  held flit count
up_en_inv_ids  out  1  held inv enable, asserted only in the LOAD cycle
up_inv_ids  out  4  held inv ids
grant_id  out  1  source owning the current upload
busy  out  1  state != IDLE
start_err  out  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset (rst low, async): state=IDLE; all up_* outputs=0; acks=0; grant_id=0; busy=0; start_err=0; last_grant=1, so req0 wins the first tie.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE (2-bit encoding).
- IDLE:
  - Both reqs valid: grant the source != last_grant.
  - One req valid: grant that source.
  - On grant: capture its fields into hold regs, set grant_id, update last_grant, go to LOAD.
  - Neither valid: stay.
- LOAD (exactly 1 cycle): up_v_flits_in=1, up_en_inv_ids=held value, ack of the granted source=1. Next state WAIT_BUSY; watchdog counter cleared.
- Latency: valid sampled in IDLE at edge T -> LOAD (strobe+ack) in cycle T+1.
- WAIT_BUSY:
  - up_fsm_state!=0: go to WAIT_DONE.
  - Otherwise increment counter; when counter reaches START_TO-1 with fsm still idle: go to IDLE and set start_err.
- WAIT_DONE: stay while up_fsm_state!=0; on 00 return to IDLE. Earliest next LOAD is 2 cycles after the datapath returns to idle.
- Hold regs stay stable from LOAD until the next grant; no other writes occur.
- Requester handshake:
  - A requester may drop valid before ack (withdraw); it is then not granted.
  - After ack, the requester presents its next message no earlier than the following cycle.
  - Valid held high continuously with new fields is a new request.
- A request arriving during LOAD/WAIT_* is only sampled in IDLE; there is no queueing inside this block.
- Simultaneous cases:
  - Both valid in IDLE: rotate. A source repeatedly valid alternates with the other.
  - Ack and a fresh valid from the other source in the same cycle: the other source waits for IDLE.
- Reset mid-upload: returns to IDLE immediately; ack/strobe drop asynchronously; datapath shares the same reset.

Decomposition:
- Shared package upload_pkg:
  - arbiter state encoding (IDLE=0, LOAD=1, WAIT_BUSY=2, WAIT_DONE=3)
  - UPLOAD_FSM_IDLE=2'b00
  - FLIT_W default
  - field widths: flits_max=4, inv_ids=4
- Sub-module upload_rr_arb2: two valid inputs, grant enable, registered last_grant pointer, one-hot grant output.
- FSM, hold registers and watchdog live in upload_arbiter.

Test Plan:
- Reset, then req0_valid with head=16'h1234, addrhi=16'hA000, flits_max=3 -> next cycle up_v_flits_in=1, req0_ack=1, up_head_flit=16'h1234; up_fsm_state 01 for 3 cycles then 00 -> back in IDLE, busy=0 one cycle later.
- req0 and req1 valid together for 4 uploads -> grants in order 0,1,0,1; grant_id matches; exactly one ack per LOAD.
- up_fsm_state held 00 after LOAD with START_TO=4 -> after 4 cycles in WAIT_BUSY state returns to IDLE; start_err=1 and stays 1 through later normal uploads.
- req1_valid asserted while busy with req0 upload (fsm 10 for 5 cycles) -> no req1_ack until 2 cycles after fsm returns 00; hold regs keep req0 fields until then.
- req0_en_inv_ids=1, inv_ids=4'b0110 -> up_en_inv_ids=1 only in the LOAD cycle; up_inv_ids=4'b0110 held through WAIT_DONE.
- rst pulled low during WAIT_DONE -> busy, up_v_flits_in, acks and up_* go 0 immediately; after release, req0 wins a tie.
